seq_alu: RTL and testbench

Parametrised, handshaked ALU for the RV32 datapath. It combines function decode (ALUOp/funct3/funct7/op bit 5) with execution, so the control unit hands over raw instruction fields. It extends the base add/sub/and/or/slt set with xor, sltu, shifts and RV32M multiply/divide. Single-cycle ops return in 1 cycle; multiply and divide are iterative (WIDTH cycles). It sits between the register-read stage and writeback, with valid/ready on both sides so the multicycle controller can stall on it.

---
 rtl/seq_alu_pkg.sv | 20 ++
 rtl/seq_alu_if.sv | 29 ++
 rtl/seq_alu_decoder.sv | 44 ++++
 rtl/seq_alu.sv | 139 +++++++++++++
 tb/tb_seq_alu.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: op, state and ALUOp encodings shared by the seq_alu slice.
package seq_alu_pkg;

    typedef enum logic [4:0] {
        ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA,
        MUL, MULHU, DIV, DIVU, REM, REMU, ILL
    } alu_op_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    function automatic logic is_div(alu_op_t o);
        return o inside {DIV, DIVU, REM, REMU};
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if: operand/result handshake bundle between the register-read stage and seq_alu.
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       ALUOp;
    logic [2:0]       funct3;
    logic             funct7b5;
    logic             funct7b0;
    logic             opb5;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Result;
    logic             Zero;
    logic             Illegal;

    modport master (
        output in_valid, ALUOp, funct3, funct7b5, funct7b0, opb5, SrcA, SrcB, out_ready,
        input  in_ready, out_valid, Result, Zero, Illegal
    );

    modport slave (
        input  in_valid, ALUOp, funct3, funct7b5, funct7b0, opb5, SrcA, SrcB, out_ready,
        output in_ready, out_valid, Result, Zero, Illegal
    );
endinterface

// File: rtl/seq_alu_decoder.sv
// seq_alu_decoder: raw instruction fields to alu_op_t plus multicycle flag.
// Divide encodings decode to ILL unless SEQ_ALU_DIV_EN is defined.
module seq_alu_decoder
    import seq_alu_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       funct7b0_i,
    input  logic       opb5_i,
    output alu_op_t    op_o,
    output logic       iter_o
);
    alu_op_t base, mext;

    always_comb begin
        case (funct3_i)
            3'b000:  base = (opb5_i & funct7b5_i) ? SUB : ADD;
            3'b001:  base = SLL;
            3'b010:  base = SLT;
            3'b011:  base = SLTU;
            3'b100:  base = XOR;
            3'b101:  base = funct7b5_i ? SRA : SRL;
            3'b110:  base = OR;
            default: base = AND;
        endcase
        case (funct3_i)
            3'b000:  mext = MUL;
            3'b011:  mext = MULHU;
`ifdef SEQ_ALU_DIV_EN
            3'b100:  mext = DIV;
            3'b101:  mext = DIVU;
            3'b110:  mext = REM;
            3'b111:  mext = REMU;
`endif
            default: mext = ILL;
        endcase
        op_o = alu_op_i == ALUOP_ADD  ? ADD :
               alu_op_i == ALUOP_SUB  ? SUB :
               alu_op_i == ALUOP_RSVD ? ILL :
               (opb5_i & funct7b0_i)  ? mext : base;
        iter_o = op_o inside {MUL, MULHU, DIV, DIVU, REM, REMU};
    end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked RV32 ALU, single-cycle base ops, iterative multiply/divide.
// Divide/remainder datapath is built only when SEQ_ALU_DIV_EN is defined.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic      clk,
    input logic      reset,
    seq_alu_if.slave bus
);
    localparam int SW = $clog2(WIDTH);
    localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

    alu_op_t            op, op_q;
    fsm_state_t         state_q;
    logic               iter, accept, zero_q, ill_q;
    logic [SW-1:0]      cnt_q, sh;
    logic [WIDTH-1:0]   a_q, res_q, sc_res, it_res, res_d;
    logic [2*WIDTH-1:0] prod_q, step, ld_prod;
    logic [WIDTH:0]     msum;

    seq_alu_decoder u_dec (
        .alu_op_i   (bus.ALUOp),
        .funct3_i   (bus.funct3),
        .funct7b5_i (bus.funct7b5),
        .funct7b0_i (bus.funct7b0),
        .opb5_i     (bus.opb5),
        .op_o       (op),
        .iter_o     (iter)
    );

    assign bus.in_ready  = (state_q == IDLE) | (state_q == DONE & bus.out_ready);
    assign bus.out_valid = state_q == DONE;
    assign bus.Result    = res_q;
    assign bus.Zero      = zero_q;
    assign bus.Illegal   = ill_q;
    assign accept        = bus.in_valid & bus.in_ready;
    assign sh            = bus.SrcB[SW-1:0];

    always_comb begin
        case (op)
            ADD:     sc_res = bus.SrcA + bus.SrcB;
            SUB:     sc_res = bus.SrcA - bus.SrcB;
            AND:     sc_res = bus.SrcA & bus.SrcB;
            OR:      sc_res = bus.SrcA | bus.SrcB;
            XOR:     sc_res = bus.SrcA ^ bus.SrcB;
            SLT:     sc_res = WIDTH'($signed(bus.SrcA) < $signed(bus.SrcB));
            SLTU:    sc_res = WIDTH'(bus.SrcA < bus.SrcB);
            SLL:     sc_res = bus.SrcA << sh;
            SRL:     sc_res = bus.SrcA >> sh;
            SRA:     sc_res = $signed(bus.SrcA) >>> sh;
            default: sc_res = '0;
        endcase
    end

`ifdef SEQ_ALU_DIV_EN
    logic             sgn, sa, sb, ge, neg_q, rneg_q;
    logic [WIDTH:0]   dt;
    logic [WIDTH-1:0] dd, b_q, q_w, r_w;

    assign sgn = op inside {DIV, REM};
    assign sa  = sgn & bus.SrcA[WIDTH-1];
    assign sb  = sgn & bus.SrcB[WIDTH-1];

    // Divide works on magnitudes; the sign fix-up flags are captured at accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            b_q    <= '0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
        end else if (accept) begin
            b_q    <= sb ? -bus.SrcB : bus.SrcB;
            neg_q  <= (sa ^ sb) & (|bus.SrcB);
            rneg_q <= sa;
        end
    end
`endif

    // prod_q holds {hi, lo}: product accumulator for mul, {remainder, quotient} for div.
    always_comb begin
        msum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
        step    = {msum, prod_q[WIDTH-1:1]};
        it_res  = op_q == MULHU ? step[2*WIDTH-1:WIDTH] : step[WIDTH-1:0];
        ld_prod = {{WIDTH{1'b0}}, bus.SrcB};
`ifdef SEQ_ALU_DIV_EN
        dt  = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
        ge  = dt >= {1'b0, b_q};
        dd  = ge ? WIDTH'(dt - {1'b0, b_q}) : dt[WIDTH-1:0];
        q_w = {prod_q[WIDTH-2:0], ge};
        r_w = dd;
        if (is_div(op_q)) begin
            step   = {r_w, q_w};
            it_res = (op_q inside {DIV, DIVU}) ? (neg_q ? -q_w : q_w) : (rneg_q ? -r_w : r_w);
        end
        if (is_div(op))
            ld_prod = {{WIDTH{1'b0}}, sa ? -bus.SrcA : bus.SrcA};
`endif
    end

    assign res_d = state_q == BUSY ? it_res : sc_res;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= ADD;
            a_q     <= '0;
            prod_q  <= '0;
            res_q   <= '0;
            zero_q  <= 1'b1;
            ill_q   <= 1'b0;
        end else if (accept) begin
            op_q <= op;
            if (iter) begin
                state_q <= BUSY;
                cnt_q   <= LAST;
                a_q     <= bus.SrcA;
                prod_q  <= ld_prod;
            end else begin
                state_q <= DONE;
                res_q   <= res_d;
                zero_q  <= res_d == '0;
                ill_q   <= op == ILL;
            end
        end else if (state_q == BUSY) begin
            prod_q <= step;
            cnt_q  <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
                state_q <= DONE;
                res_q   <= res_d;
                zero_q  <= res_d == '0;
                ill_q   <= 1'b0;
            end
        end else if (state_q == DONE & bus.out_ready) begin
            state_q <= IDLE;
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vector table plus reset, stall and back-to-back sequences for seq_alu.
module tb_seq_alu;
    typedef struct {
        logic [1:0]  aluop;
        logic [2:0]  f3;
        logic        f7b5, f7b0, opb5;
        logic [31:0] a, b, res;
        logic        z, ill;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   pass_cnt = 0;
    int   total = 0;
    int   lat, bad;
    vec_t vq[$];

    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(32)) bus ();
    seq_alu #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    function automatic vec_t mk(int aluop, int f3, int f7b5, int f7b0, int opb5,
                                logic [31:0] a, logic [31:0] b, logic [31:0] res,
                                int z, int ill, int l);
        vec_t v;
        v.aluop = 2'(aluop);
        v.f3    = 3'(f3);
        v.f7b5  = 1'(f7b5);
        v.f7b0  = 1'(f7b0);
        v.opb5  = 1'(opb5);
        v.a     = a;
        v.b     = b;
        v.res   = res;
        v.z     = 1'(z);
        v.ill   = 1'(ill);
        v.lat   = l;
        return v;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", n, act, exp);
    endtask

    task automatic drive(input vec_t v);
        bus.ALUOp    = v.aluop;
        bus.funct3   = v.f3;
        bus.funct7b5 = v.f7b5;
        bus.funct7b0 = v.f7b0;
        bus.opb5     = v.opb5;
        bus.SrcA     = v.a;
        bus.SrcB     = v.b;
        bus.in_valid = 1'b1;
    endtask

    task automatic run(input vec_t v, input string n);
        int l;
        drive(v);
        chk({n, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.SrcA = 32'hDEAD_BEEF;
        bus.SrcB = 32'h1234_5678;
        l = 0;
        while (!bus.out_valid && l < 100) begin
            if (l == 1) chk({n, "_busy_ready"}, 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            #1;
            l++;
        end
        chk({n, "_latency"}, 32'(l), 32'(v.lat));
        chk({n, "_result"}, bus.Result, v.res);
        chk({n, "_zero"}, 32'(bus.Zero), 32'(v.z));
        chk({n, "_illegal"}, 32'(bus.Illegal), 32'(v.ill));
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        bus.in_valid = 1'b0;

        vq.push_back(mk(0, 0, 0, 0, 0, 2, 3, 5, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 0, 5, 5, 0, 1, 0, 0));
        vq.push_back(mk(3, 0, 0, 0, 0, 5, 7, 0, 1, 1, 0));
        vq.push_back(mk(2, 0, 1, 0, 1, 5, 7, 32'hFFFF_FFFE, 0, 0, 0));
        vq.push_back(mk(2, 0, 1, 0, 0, 5, 7, 12, 0, 0, 0));
        vq.push_back(mk(2, 5, 1, 0, 1, 32'h8000_0000, 4, 32'hF800_0000, 0, 0, 0));
        vq.push_back(mk(2, 5, 0, 0, 1, 32'h8000_0000, 4, 32'h0800_0000, 0, 0, 0));
        vq.push_back(mk(2, 5, 0, 0, 1, 32'h8000_0000, 32'h3F, 1, 0, 0, 0));
        vq.push_back(mk(2, 1, 0, 0, 1, 1, 32'h24, 32'h10, 0, 0, 0));
        vq.push_back(mk(2, 2, 0, 0, 1, 32'hFFFF_FFFF, 1, 1, 0, 0, 0));
        vq.push_back(mk(2, 3, 0, 0, 1, 32'hFFFF_FFFF, 1, 0, 1, 0, 0));
        vq.push_back(mk(2, 4, 0, 0, 1, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 0, 0, 0));
        vq.push_back(mk(2, 6, 0, 0, 1, 32'hF0F0_0000, 32'h0000_F0F0, 32'hF0F0_F0F0, 0, 0, 0));
        vq.push_back(mk(2, 7, 0, 0, 1, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 0, 0, 0));
        vq.push_back(mk(0, 7, 1, 1, 1, 1, 1, 2, 0, 0, 0));
        vq.push_back(mk(2, 0, 0, 1, 0, 5, 7, 12, 0, 0, 0));
        vq.push_back(mk(2, 0, 0, 1, 1, 32'hFFFF_FFFF, 3, 32'hFFFF_FFFD, 0, 0, 32));
        vq.push_back(mk(2, 3, 0, 1, 1, 32'hFFFF_FFFF, 3, 2, 0, 0, 32));
        vq.push_back(mk(2, 0, 0, 1, 1, 32'h0001_2345, 32'h1000, 32'h1234_5000, 0, 0, 32));
        vq.push_back(mk(2, 3, 0, 1, 1, 32'h0001_2345, 32'h1000, 0, 1, 0, 32));
        vq.push_back(mk(2, 1, 0, 1, 1, 7, 3, 0, 1, 1, 0));
        vq.push_back(mk(2, 2, 0, 1, 1, 7, 3, 0, 1, 1, 0));
`ifdef SEQ_ALU_DIV_EN
        vq.push_back(mk(2, 4, 0, 1, 1, 7, 0, 32'hFFFF_FFFF, 0, 0, 32));
        vq.push_back(mk(2, 6, 0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 0, 32));
        vq.push_back(mk(2, 4, 0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0, 32));
        vq.push_back(mk(2, 4, 0, 1, 1, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, 0, 0, 32));
        vq.push_back(mk(2, 6, 0, 1, 1, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, 0, 0, 32));
        vq.push_back(mk(2, 5, 0, 1, 1, 100, 7, 14, 0, 0, 32));
        vq.push_back(mk(2, 7, 0, 1, 1, 100, 7, 2, 0, 0, 32));
        vq.push_back(mk(2, 4, 0, 1, 1, 32'hFFFF_FFF9, 0, 32'hFFFF_FFFF, 0, 0, 32));
        vq.push_back(mk(2, 6, 0, 1, 1, 32'hFFFF_FFF9, 0, 32'hFFFF_FFF9, 0, 0, 32));
`else
        vq.push_back(mk(2, 4, 0, 1, 1, 7, 0, 0, 1, 1, 0));
        vq.push_back(mk(2, 5, 0, 1, 1, 100, 7, 0, 1, 1, 0));
        vq.push_back(mk(2, 6, 0, 1, 1, 100, 7, 0, 1, 1, 0));
        vq.push_back(mk(2, 7, 0, 1, 1, 100, 7, 0, 1, 1, 0));
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result", bus.Result, 32'd0);
        chk("rst_zero", 32'(bus.Zero), 32'd1);
        chk("rst_illegal", 32'(bus.Illegal), 32'd0);
        reset = 1'b0;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        foreach (vq[i]) run(vq[i], $sformatf("v%0d", i));

        // reset in the middle of a multiply drops it
        drive(mk(2, 0, 0, 1, 1, 32'hFFFF_FFFF, 3, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("busy_in_ready", 32'(bus.in_ready), 32'd0);
        chk("busy_out_valid", 32'(bus.out_valid), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_result", bus.Result, 32'd0);
        chk("midrst_zero", 32'(bus.Zero), 32'd1);
        run(mk(0, 0, 0, 0, 0, 2, 3, 5, 0, 0, 0), "post_rst_add");
        bad = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) bad++;
        end
        chk("dropped_mul_silent", 32'(bad), 32'd0);

        // four adds, consumer stalls on the second result
        drive(mk(0, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        chk("s1_result", bus.Result, 32'd11);
        chk("s1_valid", 32'(bus.out_valid), 32'd1);
        drive(mk(0, 0, 0, 0, 0, 20, 2, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        chk("s2_result", bus.Result, 32'd22);
        bus.out_ready = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 30, 3, 0, 0, 0, 0));
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("s2_hold_result", bus.Result, 32'd22);
            chk("s2_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("s2_hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("s3_result", bus.Result, 32'd33);
        drive(mk(0, 0, 0, 0, 0, 40, 4, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        chk("s4_result", bus.Result, 32'd44);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("s_idle_valid", 32'(bus.out_valid), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
